// File: rtl/demux1t4_buf.sv
// demux1t4_buf: steers A into one of four one-entry output slots by S; each slot drains on its own V/R pair.
// One-cycle load latency; a full slot only stalls offers to itself. Define DEMUX_CNT_EN for per-channel delivery counters on CNT.
module demux1t4_buf #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       S,
   input  logic [WIDTH-1:0] A,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] C0,
   output logic [WIDTH-1:0] C1,
   output logic [WIDTH-1:0] C2,
   output logic [WIDTH-1:0] C3,
   output logic [3:0]       V,
   input  logic [3:0]       R
`ifdef DEMUX_CNT_EN
   ,
   output logic [63:0]      CNT
`endif
);

   logic [3:0]       r_full;
   logic [WIDTH-1:0] r_dat [4];
   logic [3:0]       w_sel;
   logic [3:0]       w_load;
   logic [3:0]       w_deliver;
   logic             w_accept;

   // A slot being drained this cycle can be refilled in the same cycle.
   assign w_sel     = 4'b0001 << S;
   assign in_ready  = ~r_full[S] | R[S];
   assign w_accept  = in_valid & in_ready;
   assign w_load    = w_sel & {4{w_accept}};
   assign w_deliver = r_full & R;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= '0;
         for (int k = 0; k < 4; k++) begin
            r_dat[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_load[k]) begin
               r_full[k] <= 1'b1;
               r_dat[k]  <= A;
            end else if (w_deliver[k]) begin
               r_full[k] <= 1'b0;
            end
         end
      end
   end

   assign V  = r_full;
   assign C0 = r_dat[0];
   assign C1 = r_dat[1];
   assign C2 = r_dat[2];
   assign C3 = r_dat[3];

`ifdef DEMUX_CNT_EN
   logic [15:0] r_cnt [4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            r_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_deliver[k]) begin
               r_cnt[k] <= r_cnt[k] + 16'd1;
            end
         end
      end
   end

   assign CNT = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_demux1t4_buf.sv
// Bench for demux1t4_buf: hand-written vector table, reset corners, then random traffic against a queue model.
module tb_demux1t4_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  S = '0;
   logic [31:0] A = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] C0, C1, C2, C3;
   logic [3:0]  V;
   logic [3:0]  R = '0;
`ifdef DEMUX_CNT_EN
   logic [63:0] CNT;
`endif

   int checks = 0;
   int failures = 0;

   demux1t4_buf #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .S(S), .A(A), .in_valid(in_valid), .in_ready(in_ready),
      .C0(C0), .C1(C1), .C2(C2), .C3(C3), .V(V), .R(R)
`ifdef DEMUX_CNT_EN
      , .CNT(CNT)
`endif
   );

   always #5 clk = ~clk;

   // Model: each channel is a mailbox holding at most one undelivered word.
   logic [31:0] mq [4][$];
   logic [31:0] m_last [4];
   int          m_cnt [4];

   typedef struct packed {
      logic [1:0]   s;
      logic [31:0]  a;
      logic         v;
      logic [3:0]   r;
      logic         rdy;
      logic [3:0]   ev;
      logic [127:0] ec;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] cw(input logic [31:0] c3, input logic [31:0] c2,
                                       input logic [31:0] c1, input logic [31:0] c0);
      return {c3, c2, c1, c0};
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 4; k++) begin
         mq[k].delete();
         m_last[k] = '0;
         m_cnt[k]  = 0;
      end
   endtask

   task automatic step(input logic [1:0] s, input logic [31:0] a, input logic v, input logic [3:0] r,
                       output logic o_rdy, output logic [3:0] o_v, output logic [127:0] o_c);
      logic       e_rdy;
      logic [3:0] e_v;
      @(negedge clk);
      S = s; A = a; in_valid = v; R = r;
      #1;
      e_rdy = (mq[s].size() == 0) || r[s];
      o_rdy = in_ready;
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         if (mq[k].size() != 0 && r[k]) begin
            void'(mq[k].pop_front());
            m_cnt[k] = (m_cnt[k] + 1) % 65536;
         end
      end
      if (v && e_rdy) begin
         mq[s].push_back(a);
         m_last[s] = a;
      end
      #1;
      for (int k = 0; k < 4; k++) e_v[k] = (mq[k].size() != 0);
      chk("V", 64'(V), 64'(e_v));
      chk("C0", 64'(C0), 64'(m_last[0]));
      chk("C1", 64'(C1), 64'(m_last[1]));
      chk("C2", 64'(C2), 64'(m_last[2]));
      chk("C3", 64'(C3), 64'(m_last[3]));
`ifdef DEMUX_CNT_EN
      chk("CNT", CNT, {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])});
`endif
      o_v = V;
      o_c = {C3, C2, C1, C0};
   endtask

   // Reset is raised between clock edges so its effect must be immediate.
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_V", 64'(V), 64'd0);
      chk("rst_C", {C1, C0} | {C3, C2}, 64'd0);
`ifdef DEMUX_CNT_EN
      chk("rst_CNT", CNT, 64'd0);
`endif
      model_clear();
      in_valid = 1'b0;
      R = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic         o_rdy;
      logic [3:0]   o_v;
      logic [127:0] o_c;

      model_clear();
      do_reset();

      // Fill every channel with no sink ready, then reset mid-transfer.
      for (int k = 0; k < 4; k++) step(2'(k), 32'h100 + 32'(k), 1'b1, 4'b0000, o_rdy, o_v, o_c);
      chk("all_full", 64'(V), 64'hF);
      do_reset();
      for (int s = 0; s < 4; s++) begin
         S = 2'(s);
         #1;
         chk("post_rst_ready", 64'(in_ready), 64'd1);
      end

      //             s      a             v     r        rdy   V        {C3,C2,C1,C0}
      tbl[0]  = '{2'd0, 32'd0,        1'b1, 4'hF,    1'b1, 4'b0001, cw(0, 0, 0, 0)};
      tbl[1]  = '{2'd1, 32'd1,        1'b1, 4'hF,    1'b1, 4'b0010, cw(0, 0, 1, 0)};
      tbl[2]  = '{2'd2, 32'd2,        1'b1, 4'hF,    1'b1, 4'b0100, cw(0, 2, 1, 0)};
      tbl[3]  = '{2'd3, 32'd3,        1'b1, 4'hF,    1'b1, 4'b1000, cw(3, 2, 1, 0)};
      tbl[4]  = '{2'd0, 32'd0,        1'b0, 4'hF,    1'b1, 4'b0000, cw(3, 2, 1, 0)};
      tbl[5]  = '{2'd2, 32'hAAAA,     1'b1, 4'b0000, 1'b1, 4'b0100, cw(3, 32'hAAAA, 1, 0)};
      tbl[6]  = '{2'd2, 32'hBBBB,     1'b1, 4'b0000, 1'b0, 4'b0100, cw(3, 32'hAAAA, 1, 0)};
      tbl[7]  = '{2'd2, 32'hBBBB,     1'b1, 4'b0000, 1'b0, 4'b0100, cw(3, 32'hAAAA, 1, 0)};
      tbl[8]  = '{2'd2, 32'hBBBB,     1'b1, 4'b0000, 1'b0, 4'b0100, cw(3, 32'hAAAA, 1, 0)};
      tbl[9]  = '{2'd2, 32'hBBBB,     1'b1, 4'b0100, 1'b1, 4'b0100, cw(3, 32'hBBBB, 1, 0)};
      tbl[10] = '{2'd0, 32'd0,        1'b0, 4'b0100, 1'b1, 4'b0000, cw(3, 32'hBBBB, 1, 0)};
      tbl[11] = '{2'd1, 32'd5,        1'b1, 4'b0000, 1'b1, 4'b0010, cw(3, 32'hBBBB, 5, 0)};
      tbl[12] = '{2'd3, 32'd7,        1'b1, 4'b0000, 1'b1, 4'b1010, cw(7, 32'hBBBB, 5, 0)};
      tbl[13] = '{2'd0, 32'd0,        1'b0, 4'b1010, 1'b1, 4'b0000, cw(7, 32'hBBBB, 5, 0)};
      tbl[14] = '{2'd0, 32'd10,       1'b1, 4'b0001, 1'b1, 4'b0001, cw(7, 32'hBBBB, 5, 10)};
      tbl[15] = '{2'd0, 32'd11,       1'b1, 4'b0001, 1'b1, 4'b0001, cw(7, 32'hBBBB, 5, 11)};
      tbl[16] = '{2'd0, 32'd12,       1'b1, 4'b0001, 1'b1, 4'b0001, cw(7, 32'hBBBB, 5, 12)};
      tbl[17] = '{2'd0, 32'd0,        1'b0, 4'b0001, 1'b1, 4'b0000, cw(7, 32'hBBBB, 5, 12)};

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].s, tbl[i].a, tbl[i].v, tbl[i].r, o_rdy, o_v, o_c);
         chk($sformatf("tbl%0d_rdy", i), 64'(o_rdy), 64'(tbl[i].rdy));
         chk($sformatf("tbl%0d_V", i), 64'(o_v), 64'(tbl[i].ev));
         chk($sformatf("tbl%0d_C", i), o_c[63:0], tbl[i].ec[63:0]);
         chk($sformatf("tbl%0d_Chi", i), o_c[127:64], tbl[i].ec[127:64]);
      end

      for (int i = 0; i < 600; i++) begin
         step(2'($urandom_range(3)), $urandom, 1'($urandom_range(1)), 4'($urandom_range(15)),
              o_rdy, o_v, o_c);
         if (i == 300) do_reset();
      end

`ifdef DEMUX_CNT_EN
      do_reset();
      for (int i = 0; i < 5; i++) step(2'd1, 32'(200 + i), 1'b1, 4'b0010, o_rdy, o_v, o_c);
      step(2'd0, 32'd0, 1'b0, 4'b0010, o_rdy, o_v, o_c);
      chk("cnt1_five", 64'(CNT[31:16]), 64'd5);
      do_reset();
      chk("cnt_cleared", CNT, 64'd0);
      for (int i = 0; i < 65536; i++) step(2'd0, 32'(i), 1'b1, 4'b0001, o_rdy, o_v, o_c);
      chk("cnt0_ffff", 64'(CNT[15:0]), 64'hFFFF);
      step(2'd0, 32'd0, 1'b0, 4'b0001, o_rdy, o_v, o_c);
      chk("cnt0_wrap", 64'(CNT[15:0]), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
